gpu_task_dispatcher: RTL
========================

Name: gpu_task_dispatcher

Overview:
- Transmitter side of the core instruction-load handshake (rtr / val_ins / instruction / ready).
- Holds a host-loaded task store of TASK_DEPTH programs, each exactly 16 × 16-bit instructions.
- On start, streams tasks round-robin to idle cores over a shared instruction bus, tracks per-core completion and raises done when every task has finished.
- Sits between the host/control port and the NUM_CORES GPU cores.

Parameters:
NUM_CORES, 8, number of attached cores (one val_ins/rtr/ready bit each)
TASK_DEPTH, 16, number of 16-word programs the task store holds (power of 2)
TASK_AW, 4, log2(TASK_DEPTH)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
host_we  in  1  task-store write strobe; ignored while busy=1
host_addr  in  TASK_AW+4  {task index, word index[3:0]}
host_wdata  in  16  instruction word to store
num_tasks  in  TASK_AW+1  tasks to run (0..TASK_DEPTH), sampled on start
start  in  1  one-cycle run request; honoured only in IDLE
core_rtr  in  NUM_CORES  per-core ready-to-receive
core_ready  in  NUM_CORES  per-core program-finished flag
val_ins  out  NUM_CORES  one-hot instruction-valid, registered
instruction  out  16  shared instruction bus, registered
busy  out  1  run in progress
done  out  1  all tasks complete; held until next start
tasks_done  out  TASK_AW+1  completed-task count of current run

Behaviour:
- Reset: val_ins=0, instruction=0, busy=0, done=0, tasks_done=0, rr pointer=0, all core_busy flags=0, state=IDLE. Task store contents are not cleared. Reset mid-run aborts the run with no further val_ins.
- Task store: synchronous write; combinational read.
- IDLE:
  - start with num_tasks=0 -> done=1, stay IDLE.
  - start with num_tasks>0 -> latch num_tasks, next_task=0, tasks_done=0, done=0, busy=1, go to SELECT.
- SELECT: eligible core = core_rtr[c]=1 and core_busy[c]=0.
  - Pick the first eligible core searching from rr pointer upward with wrap.
  - None eligible -> stay.
  - Otherwise latch core c, word=0, go to SEND.
- SEND: exactly 16 consecutive cycles.
  - val_ins = one-hot(c); instruction = store[next_task][word]; word increments each cycle.
  - No gaps; core_rtr is not re-checked mid-burst.
  - After word 15: val_ins=0 on the next cycle, core_busy[c]=1, rr=c+1 (mod NUM_CORES), next_task++.
  - next_task==num_tasks -> DRAIN, else SELECT.
- Completion, every cycle in any state: core_busy[c]=1 and core_ready[c]=1 -> clear core_busy[c], tasks_done++.
  - Several cores completing in the same cycle all count.
  - A core's ready drops during its burst, so a stale ready is never seen once core_busy is set.
- DRAIN: wait until all core_busy=0, then busy=0, done=1, go to IDLE.
- A core becomes eligible again only when its rtr returns to 1 after completion; one cycle of rtr=0 after finish is normal.
- Host writes during busy=1 are dropped.
- start while busy=1 is ignored.

Test Plan:
- Load task 0 with words 0x1000..0x100F; num_tasks=1; start -> val_ins=8'b0000_0001 for exactly 16 cycles carrying 0x1000..0x100F in order; core 0 ready=1 after 40 cycles -> tasks_done=1, done=1, busy=0.
- num_tasks=3, all cores idle -> bursts go to cores 0, 1, 2 back-to-back, each one-hot and 16 cycles, with a single SELECT cycle between bursts.
- NUM_CORES=8, num_tasks=10, cores return ready in staggered order -> tasks 8 and 9 go to the first cores whose rtr returns, searching from rr=0 (wrapped); final tasks_done=10.
- core_rtr=0 on all cores after start -> dispatcher holds in SELECT with val_ins=0; rtr[5]=1 -> the next burst targets core 5.
- start with num_tasks=0 -> done=1 on the next cycle, no val_ins; host_we during a run leaves the store unchanged (verified by a rerun).
- Assert reset on word 7 of a burst -> next cycle val_ins=0, busy=0, done=0, tasks_done=0; a fresh start then dispatches task 0 again from word 0.

Source files
------------

// File: rtl/gpu_task_dispatcher.sv
// Task dispatcher: holds host-loaded 16-word programs and streams them round-robin
// to idle GPU cores over a shared instruction bus, counting completions per run.
module gpu_task_dispatcher #(
   parameter int NUM_CORES  = 8,
   parameter int TASK_DEPTH = 16,
   parameter int TASK_AW    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 host_we,
   input  logic [TASK_AW+3:0]   host_addr,
   input  logic [15:0]          host_wdata,
   input  logic [TASK_AW:0]     num_tasks,
   input  logic                 start,
   input  logic [NUM_CORES-1:0] core_rtr,
   input  logic [NUM_CORES-1:0] core_ready,
   output logic [NUM_CORES-1:0] val_ins,
   output logic [15:0]          instruction,
   output logic                 busy,
   output logic                 done,
   output logic [TASK_AW:0]     tasks_done
);

   localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {IDLE, SELECT, SEND, DRAIN} state_t;

   state_t               state_reg, state_next;
   logic [TASK_AW:0]     num_tasks_reg, num_tasks_next;
   logic [TASK_AW:0]     next_task_reg, next_task_next;
   logic [TASK_AW:0]     tasks_done_reg, tasks_done_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic [CW-1:0]        rr_reg, rr_next;
   logic [CW-1:0]        core_sel_reg, core_sel_next;
   logic [3:0]           word_reg, word_next;
   logic [NUM_CORES-1:0] core_busy_reg, core_busy_next;
   logic [NUM_CORES-1:0] val_ins_reg, val_ins_next;
   logic [15:0]          instruction_reg, instruction_next;

   logic [15:0]          store_mem [TASK_DEPTH*16];
   logic [3:0]           rd_word;
   logic [15:0]          rd_data;
   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] clear_mask;
   logic [NUM_CORES-1:0] set_mask;
   logic [TASK_AW:0]     done_cnt;
   logic [TASK_AW:0]     task_inc;
   logic                 found;
   logic [CW-1:0]        pick;
   logic [CW:0]          rr_sum;

   always_ff @(posedge clk) begin
      if (host_we && !busy_reg)
         store_mem[host_addr] <= host_wdata;
   end

   // Prefetch the word that will be on the bus next cycle.
   assign rd_word = (state_reg == SEND) ? word_reg + 4'd1 : 4'd0;
   assign rd_data = store_mem[{next_task_reg[TASK_AW-1:0], rd_word}];

   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
         assign eligible[gi]   = core_rtr[gi] & ~core_busy_reg[gi];
         assign clear_mask[gi] = core_busy_reg[gi] & core_ready[gi];
      end
   endgenerate

   assign task_inc = next_task_reg + (TASK_AW+1)'(1);

   always_comb begin
      found  = 1'b0;
      pick   = '0;
      rr_sum = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         rr_sum = {1'b0, rr_reg} + (CW+1)'(i);
         if (rr_sum >= (CW+1)'(NUM_CORES))
            rr_sum = rr_sum - (CW+1)'(NUM_CORES);
         if (!found && eligible[rr_sum[CW-1:0]]) begin
            found = 1'b1;
            pick  = rr_sum[CW-1:0];
         end
      end
   end

   always_comb begin
      done_cnt = '0;
      for (int i = 0; i < NUM_CORES; i++)
         done_cnt = done_cnt + (TASK_AW+1)'(clear_mask[i]);
   end

   always_comb begin
      state_next       = state_reg;
      num_tasks_next   = num_tasks_reg;
      next_task_next   = next_task_reg;
      tasks_done_next  = tasks_done_reg + done_cnt;
      busy_next        = busy_reg;
      done_next        = done_reg;
      rr_next          = rr_reg;
      core_sel_next    = core_sel_reg;
      word_next        = word_reg;
      val_ins_next     = val_ins_reg;
      instruction_next = instruction_reg;
      set_mask         = '0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               tasks_done_next = '0;
               if (num_tasks == '0) begin
                  done_next = 1'b1;
               end else begin
                  num_tasks_next = num_tasks;
                  next_task_next = '0;
                  done_next      = 1'b0;
                  busy_next      = 1'b1;
                  state_next     = SELECT;
               end
            end
         end
         SELECT: begin
            if (found) begin
               core_sel_next    = pick;
               word_next        = 4'd0;
               val_ins_next     = NUM_CORES'(1) << pick;
               instruction_next = rd_data;
               state_next       = SEND;
            end
         end
         SEND: begin
            if (word_reg == 4'hF) begin
               val_ins_next   = '0;
               set_mask       = NUM_CORES'(1) << core_sel_reg;
               rr_next        = (core_sel_reg == CW'(NUM_CORES-1)) ? '0 : core_sel_reg + CW'(1);
               next_task_next = task_inc;
               state_next     = (task_inc == num_tasks_reg) ? DRAIN : SELECT;
            end else begin
               word_next        = word_reg + 4'd1;
               instruction_next = rd_data;
            end
         end
         DRAIN: begin
            if (core_busy_reg == '0) begin
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      core_busy_next = (core_busy_reg & ~clear_mask) | set_mask;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         num_tasks_reg   <= '0;
         next_task_reg   <= '0;
         tasks_done_reg  <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         rr_reg          <= '0;
         core_sel_reg    <= '0;
         word_reg        <= '0;
         core_busy_reg   <= '0;
         val_ins_reg     <= '0;
         instruction_reg <= '0;
      end else begin
         state_reg       <= state_next;
         num_tasks_reg   <= num_tasks_next;
         next_task_reg   <= next_task_next;
         tasks_done_reg  <= tasks_done_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
         rr_reg          <= rr_next;
         core_sel_reg    <= core_sel_next;
         word_reg        <= word_next;
         core_busy_reg   <= core_busy_next;
         val_ins_reg     <= val_ins_next;
         instruction_reg <= instruction_next;
      end
   end

   assign val_ins     = val_ins_reg;
   assign instruction = instruction_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign tasks_done  = tasks_done_reg;

endmodule
